// File: rtl/stage_decode_if.sv
// Decode-stage bus bundle: fetch handshake, execute issue/redirect, and register writeback.
// The master modport is the decode stage; the slave modport is the surrounding pipeline.
interface stage_decode_if;
  logic        de_valid;
  logic [31:0] de_insn;
  logic [31:0] de_pc;
  logic        de_stall;
  logic        de_setpc;
  logic [31:0] de_newpc;
  logic        ex_stall;
  logic        ex_setpc;
  logic [31:0] ex_newpc;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic        ex_src_a_pc;
  logic        ex_src_b_imm;
  logic [4:0]  ex_ctl;

  modport master (
    input  de_valid, de_insn, de_pc, ex_stall, ex_setpc, ex_newpc, wb_en, wb_rd, wb_data,
    output de_stall, de_setpc, de_newpc, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
           ex_rd, ex_alu_op, ex_funct3, ex_src_a_pc, ex_src_b_imm, ex_ctl
  );
  modport slave (
    output de_valid, de_insn, de_pc, ex_stall, ex_setpc, ex_newpc, wb_en, wb_rd, wb_data,
    input  de_stall, de_setpc, de_newpc, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
           ex_rd, ex_alu_op, ex_funct3, ex_src_a_pc, ex_src_b_imm, ex_ctl
  );
endinterface

// File: rtl/stage_decode.sv
// RV32I decode stage: register file, immediate generation, load-use interlock,
// local JAL resolution and redirect muxing toward fetch.
module stage_decode #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  stage_decode_if.master dec_if
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_PASSB = 4'd10;

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_sel = 4'd2;
      3'd2:    alu_sel = 4'd3;
      3'd3:    alu_sel = 4'd4;
      3'd4:    alu_sel = 4'd5;
      3'd5:    alu_sel = alt ? 4'd7 : 4'd6;
      3'd6:    alu_sel = 4'd8;
      default: alu_sel = 4'd9;
    endcase
  endfunction

  logic        hold_valid_q, hold_valid_d, ignore_fe_q;
  logic [31:0] hold_insn_q, hold_pc_q;
  logic [31:0] rf_q [0:31];

  logic        ex_valid_q, ex_src_a_q, ex_src_b_q;
  logic [31:0] ex_pc_q, ex_rs1_q, ex_rs2_q, ex_imm_q;
  logic [4:0]  ex_rd_q, ex_ctl_q;
  logic [3:0]  ex_alu_q;
  logic [2:0]  ex_f3_q;

  logic        cur_valid, lu, stall, jal_fire;
  logic [31:0] cur_insn, cur_pc, rs1_val, rs2_val;
  logic [6:0]  opcode, f7;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic        d_src_a, d_src_b, rs1_used, rs2_used;
  logic [31:0] d_imm;
  logic [4:0]  d_rd, d_ctl;
  logic [3:0]  d_alu;

  assign cur_valid = hold_valid_q | (dec_if.de_valid & ~ignore_fe_q);
  assign cur_insn  = hold_valid_q ? hold_insn_q : dec_if.de_insn;
  assign cur_pc    = hold_valid_q ? hold_pc_q   : dec_if.de_pc;

  assign opcode = cur_insn[6:0];
  assign rd     = cur_insn[11:7];
  assign f3     = cur_insn[14:12];
  assign rs1    = cur_insn[19:15];
  assign rs2    = cur_insn[24:20];
  assign f7     = cur_insn[31:25];

  assign imm_i = {{20{cur_insn[31]}}, cur_insn[31:20]};
  assign imm_s = {{20{cur_insn[31]}}, cur_insn[31:25], cur_insn[11:7]};
  assign imm_b = {{19{cur_insn[31]}}, cur_insn[31], cur_insn[7], cur_insn[30:25], cur_insn[11:8], 1'b0};
  assign imm_u = {cur_insn[31:12], 12'h000};
  assign imm_j = {{11{cur_insn[31]}}, cur_insn[31], cur_insn[19:12], cur_insn[20], cur_insn[30:21], 1'b0};

  always_comb begin
    d_imm    = '0;
    d_rd     = rd;
    d_alu    = ALU_ADD;
    d_src_a  = 1'b0;
    d_src_b  = 1'b0;
    d_ctl    = '0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_LUI:   begin d_imm = imm_u; d_alu = ALU_PASSB; d_src_b = 1'b1; rs1_used = 1'b0; end
      OP_AUIPC: begin d_imm = imm_u; d_src_a = 1'b1; d_src_b = 1'b1; rs1_used = 1'b0; end
      OP_JAL:   begin d_imm = 32'd4; d_src_a = 1'b1; d_src_b = 1'b1; rs1_used = 1'b0; end
      OP_JALR:  begin d_imm = imm_i; d_src_b = 1'b1; d_ctl[1] = 1'b1; end
      OP_BR:    begin d_imm = imm_b; d_rd = '0; d_alu = ALU_SUB; d_ctl[2] = 1'b1; rs2_used = 1'b1; end
      OP_LD:    begin d_imm = imm_i; d_src_b = 1'b1; d_ctl[4] = 1'b1; end
      OP_ST:    begin d_imm = imm_s; d_rd = '0; d_src_b = 1'b1; d_ctl[3] = 1'b1; rs2_used = 1'b1; end
      OP_IMM: begin
        if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
          d_rd = '0; d_ctl[0] = 1'b1;
        end else begin
          d_imm = imm_i; d_src_b = 1'b1; d_alu = alu_sel(f3, f3 == 3'd5 && cur_insn[30]);
        end
      end
      OP_REG: begin
        rs2_used = 1'b1;
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          d_alu = alu_sel(f3, cur_insn[30]);
        end else begin
          d_rd = '0; d_ctl[0] = 1'b1;
        end
      end
      default:  begin d_rd = '0; d_ctl[0] = 1'b1; end
    endcase
  end

  // Operand read with optional same-cycle writeback forwarding; x0 always reads zero
  always_comb begin
    rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    if (WB_BYPASS && dec_if.wb_en && dec_if.wb_rd != 5'd0) begin
      if (dec_if.wb_rd == rs1) rs1_val = dec_if.wb_data;
      if (dec_if.wb_rd == rs2) rs2_val = dec_if.wb_data;
    end
  end

  assign lu = ex_valid_q & ex_ctl_q[4] & (ex_rd_q != 5'd0) & cur_valid &
              ((rs1_used & (rs1 == ex_rd_q)) | (rs2_used & (rs2 == ex_rd_q)));
  assign stall    = dec_if.ex_stall | lu;
  assign jal_fire = cur_valid & (opcode == OP_JAL) & ~stall & ~dec_if.ex_setpc;

  assign dec_if.de_stall = stall;
  assign dec_if.de_setpc = dec_if.ex_setpc | jal_fire;
  assign dec_if.de_newpc = dec_if.ex_setpc ? dec_if.ex_newpc : cur_pc + imm_j;

  always_comb begin
    hold_valid_d = hold_valid_q;
    if (dec_if.ex_setpc)          hold_valid_d = 1'b0;
    else if (cur_valid && stall)  hold_valid_d = 1'b1;
    else if (!stall)              hold_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (dec_if.wb_en && dec_if.wb_rd != 5'd0) rf_q[dec_if.wb_rd] <= dec_if.wb_data;
    if (cur_valid && stall && !dec_if.ex_setpc) begin
      hold_insn_q <= cur_insn;
      hold_pc_q   <= cur_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_valid_q <= 1'b0;
      ignore_fe_q  <= 1'b0;
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      ex_alu_q     <= '0;
      ex_f3_q      <= '0;
      ex_src_a_q   <= 1'b0;
      ex_src_b_q   <= 1'b0;
      ex_ctl_q     <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      ignore_fe_q  <= stall;
      if (!dec_if.ex_stall) begin
        ex_valid_q <= cur_valid & ~lu & ~dec_if.ex_setpc;
        ex_pc_q    <= cur_pc;
        ex_rs1_q   <= rs1_val;
        ex_rs2_q   <= rs2_val;
        ex_imm_q   <= d_imm;
        ex_rd_q    <= d_rd;
        ex_alu_q   <= d_alu;
        ex_f3_q    <= f3;
        ex_src_a_q <= d_src_a;
        ex_src_b_q <= d_src_b;
        ex_ctl_q   <= d_ctl;
      end
    end
  end

  assign dec_if.ex_valid     = ex_valid_q;
  assign dec_if.ex_pc        = ex_pc_q;
  assign dec_if.ex_rs1_val   = ex_rs1_q;
  assign dec_if.ex_rs2_val   = ex_rs2_q;
  assign dec_if.ex_imm       = ex_imm_q;
  assign dec_if.ex_rd        = ex_rd_q;
  assign dec_if.ex_alu_op    = ex_alu_q;
  assign dec_if.ex_funct3    = ex_f3_q;
  assign dec_if.ex_src_a_pc  = ex_src_a_q;
  assign dec_if.ex_src_b_imm = ex_src_b_q;
  assign dec_if.ex_ctl       = ex_ctl_q;
endmodule
